// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// Each grant runs IDLE -> BUSY -> DONE; a watchdog aborts accesses that never see mem_ack.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // r_cnt counts completed BUSY cycles, so the last allowed cycle is TIMEOUT-1
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t          r_state;
  logic            r_last_data;
  logic            r_owner_data;
  logic [CW-1:0]   r_cnt;

  logic            r_i_ack;
  logic [DW-1:0]   r_i_rdata;
  logic            r_i_err;
  logic            r_d_ack;
  logic [DW-1:0]   r_d_rdata;
  logic            r_d_err;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic            r_busy;

  logic            w_any_req;
  logic            w_grant_data;
  logic            w_timeout;

  assign w_any_req    = i_req | d_req;
  // Data wins when alone, or on contention when fetch was served last
  assign w_grant_data = d_req & (~i_req | ~r_last_data);
  assign w_timeout    = (r_cnt == TO_LAST);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= ST_IDLE;
      r_last_data  <= 1'b1;
      r_owner_data <= 1'b0;
      r_cnt        <= '0;
      r_i_ack      <= 1'b0;
      r_i_rdata    <= '0;
      r_i_err      <= 1'b0;
      r_d_ack      <= 1'b0;
      r_d_rdata    <= '0;
      r_d_err      <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_owner_data <= w_grant_data;
            r_last_data  <= w_grant_data;
            r_mem_addr   <= w_grant_data ? d_addr : i_addr;
            r_mem_we     <= w_grant_data & d_we;
            r_mem_wdata  <= w_grant_data ? d_wdata : '0;
            r_mem_req    <= 1'b1;
            r_busy       <= 1'b1;
            r_cnt        <= '0;
            r_state      <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_DONE;
            if (r_owner_data) begin
              r_d_ack   <= 1'b1;
              r_d_err   <= 1'b0;
              r_d_rdata <= r_mem_we ? '0 : mem_rdata;
            end else begin
              r_i_ack   <= 1'b1;
              r_i_err   <= 1'b0;
              r_i_rdata <= mem_rdata;
            end
          end else if (w_timeout) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_DONE;
            if (r_owner_data) begin
              r_d_ack   <= 1'b1;
              r_d_err   <= 1'b1;
              r_d_rdata <= '0;
            end else begin
              r_i_ack   <= 1'b1;
              r_i_err   <= 1'b1;
              r_i_rdata <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        ST_DONE: begin
          r_i_ack <= 1'b0;
          r_i_err <= 1'b0;
          r_d_ack <= 1'b0;
          r_d_err <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign i_ack     = r_i_ack;
  assign i_rdata   = r_i_rdata;
  assign i_err     = r_i_err;
  assign d_ack     = r_d_ack;
  assign d_rdata   = r_d_rdata;
  assign d_err     = r_d_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: two instances (TIMEOUT=15 and TIMEOUT=2) share one stimulus.
module tb_mem_arbiter;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        i_ack, i_err, d_ack, d_err, mem_req, mem_we, busy;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  logic        i_ack2, i_err2, d_ack2, d_err2, mem_req2, mem_we2, busy2;
  logic [31:0] i_rdata2, d_rdata2, mem_addr2, mem_wdata2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
    .Clk(Clk), .Rst(Rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(2)) dut2 (
    .Clk(Clk), .Rst(Rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack2), .i_rdata(i_rdata2), .i_err(i_err2),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack2), .d_rdata(d_rdata2), .d_err(d_err2),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy2)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    Rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    Rst = 1'b0;

    // Single load, memory answers in one cycle
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    tick();
    chk("ld_mem_req", {31'd0, mem_req}, 32'd1);
    chk("ld_mem_addr", mem_addr, 32'h40);
    chk("ld_mem_we", {31'd0, mem_we}, 32'd0);
    chk("ld_busy", {31'd0, busy}, 32'd1);
    chk("ld_no_early_ack", {31'd0, d_ack}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    chk("ld_d_ack", {31'd0, d_ack}, 32'd1);
    chk("ld_d_rdata", d_rdata, 32'hDEADBEEF);
    chk("ld_d_err", {31'd0, d_err}, 32'd0);
    chk("ld_i_ack", {31'd0, i_ack}, 32'd0);
    chk("ld_mem_req_low", {31'd0, mem_req}, 32'd0);
    mem_ack = 1'b0; d_req = 1'b0;
    tick();
    chk("ld_ack_cleared", {31'd0, d_ack}, 32'd0);
    chk("ld_idle_busy", {31'd0, busy}, 32'd0);
    chk("ld_rdata_held", d_rdata, 32'hDEADBEEF);

    // Contention after reset: fetch, data, fetch
    Rst = 1'b1; tick(); Rst = 1'b0;
    i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("rr_mem_req", {31'd0, mem_req}, 32'd1);
      chk("rr_mem_addr", mem_addr, (t == 1) ? 32'h200 : 32'h100);
      tick();
      chk("rr_i_ack", {31'd0, i_ack}, (t == 1) ? 32'd0 : 32'd1);
      chk("rr_d_ack", {31'd0, d_ack}, (t == 1) ? 32'd1 : 32'd0);
      tick();
      chk("rr_done_busy", {31'd0, busy}, 32'd0);
      if (t == 2) begin
        i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
      end
    end
    chk("rr_i_rdata", i_rdata, 32'h11111111);

    // Store with four wait cycles
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h12345678;
    tick();
    chk("st_mem_we", {31'd0, mem_we}, 32'd1);
    chk("st_mem_wdata", mem_wdata, 32'h12345678);
    chk("st_mem_addr", mem_addr, 32'h80);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("st_wait_req", {31'd0, mem_req}, 32'd1);
      chk("st_wait_ack", {31'd0, d_ack}, 32'd0);
    end
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick();
    chk("st_d_ack", {31'd0, d_ack}, 32'd1);
    chk("st_d_rdata", d_rdata, 32'd0);
    chk("st_mem_req_low", {31'd0, mem_req}, 32'd0);
    mem_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
    tick();

    // Fetch timeout (TIMEOUT=15), then a late mem_ack
    i_req = 1'b1; i_addr = 32'h300;
    tick();
    chk("to_mem_req", {31'd0, mem_req}, 32'd1);
    for (int k = 1; k < 15; k++) begin
      tick();
      chk("to_wait_ack", {30'd0, i_ack, mem_req}, 32'd1);
    end
    tick();
    chk("to_i_ack", {31'd0, i_ack}, 32'd1);
    chk("to_i_err", {31'd0, i_err}, 32'd1);
    chk("to_i_rdata", i_rdata, 32'd0);
    chk("to_mem_req_low", {31'd0, mem_req}, 32'd0);
    i_req = 1'b0;
    tick();
    chk("to_ack_clear", {30'd0, i_ack, i_err}, 32'd0);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h77777777;
    tick();
    mem_ack = 1'b0;
    chk("late_ack_i", {31'd0, i_ack}, 32'd0);
    tick();
    chk("late_ack_none", {29'd0, i_ack, d_ack, busy}, 32'd0);
    chk("late_ack_rdata", i_rdata, 32'd0);

    // Reset in the middle of BUSY
    i_req = 1'b1; i_addr = 32'h400;
    tick(); tick();
    chk("rm_busy_before", {31'd0, mem_req}, 32'd1);
    Rst = 1'b1;
    tick();
    chk("rm_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rm_busy", {31'd0, busy}, 32'd0);
    chk("rm_acks", {30'd0, i_ack, d_ack}, 32'd0);
    Rst = 1'b0;
    tick();
    chk("rm_regrant", {31'd0, mem_req}, 32'd1);
    chk("rm_regrant_addr", mem_addr, 32'h400);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    chk("rm_i_ack", {31'd0, i_ack}, 32'd1);
    chk("rm_i_rdata", i_rdata, 32'hCAFEF00D);
    mem_ack = 1'b0; i_req = 1'b0;
    tick();

    // TIMEOUT=2 instance: ack on the last BUSY cycle beats the timeout
    Rst = 1'b1; tick(); Rst = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    tick();
    chk("sc_mem_req", {31'd0, mem_req2}, 32'd1);
    tick();
    chk("sc_wait", {30'd0, d_ack2, mem_req2}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h5A5A0001;
    tick();
    chk("sc_d_ack", {31'd0, d_ack2}, 32'd1);
    chk("sc_d_err", {31'd0, d_err2}, 32'd0);
    chk("sc_d_rdata", d_rdata2, 32'h5A5A0001);
    mem_ack = 1'b0; d_req = 1'b0;
    tick();
    d_req = 1'b1;
    tick(); tick();
    chk("sc_to_wait", {31'd0, d_ack2}, 32'd0);
    tick();
    chk("sc_to_ack", {31'd0, d_ack2}, 32'd1);
    chk("sc_to_err", {31'd0, d_err2}, 32'd1);
    chk("sc_to_rdata", d_rdata2, 32'd0);
    d_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
